alu_seq: RTL and testbench

- Next-generation datapath ALU for the CR16-style core; replaces the purely combinational ALU.
- Width is parametrised.
- The processor status register (PSR) is held inside the block, so flags persist between instructions.
- Adds add-with-carry, a logical shift and an iterative multiply, with a start/busy/done handshake.
- Sits between the register file read ports and the writeback mux. The controller stalls on busy.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/seq_multiplier.sv | 58 +++++
 rtl/alu_seq.sv | 156 +++++++++++++++
 tb/tb_alu_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, PSR bit positions and control-state encoding for alu_seq.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0001;
   localparam logic [3:0] OP_OR   = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_LSH  = 4'b0100;
   localparam logic [3:0] OP_ADD  = 4'b0101;
   localparam logic [3:0] OP_ADDC = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1001;
   localparam logic [3:0] OP_CMP  = 4'b1011;
   localparam logic [3:0] OP_MOV  = 4'b1101;
   localparam logic [3:0] OP_MUL  = 4'b1110;

   localparam int unsigned PSR_L = 0;
   localparam int unsigned PSR_N = 1;
   localparam int unsigned PSR_F = 2;
   localparam int unsigned PSR_C = 3;
   localparam int unsigned PSR_Z = 4;

   typedef enum logic [1:0] {IDLE, EXEC, MULT} state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// product carries the final accumulation combinationally so it is valid in the
// same cycle mul_done is high.
module seq_multiplier
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] product,
   output logic             mul_done
);

   localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

   logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             run_q;
   logic [WIDTH-1:0] acc_next;

   // Accumulate the shifted multiplicand when the current multiplier bit is set.
   always_comb begin
      acc_next = acc_q;
      if (mplier_q[0]) acc_next = acc_q + mcand_q;
   end

   assign product  = acc_next;
   assign mul_done = run_q && (cnt_q == CNT_W'(1));

   // Shift/accumulate registers and iteration counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (go) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= CNT_W'(MUL_CYCLES);
         run_q    <= 1'b1;
      end else if (run_q) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - CNT_W'(1);
         if (mul_done) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with internal PSR. Single-cycle ops complete one cycle after
// accept; MUL runs on seq_multiplier with busy held until the result lands.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned SHAMT_W    = 5,
   parameter int unsigned MUL_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alucont,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [7:0]       psr
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] result_q, result_d;
   logic [7:0]       psr_q, psr_d;
   logic             done_q, done_d;

   logic             accept, mul_go, mul_done;
   logic [WIDTH-1:0] product;

   logic             cin;
   logic [WIDTH:0]   sum, diff;
   logic [SHAMT_W-1:0] sh;
   logic [SHAMT_W:0]   mag;
   logic [WIDTH-1:0]   shift_res;

   assign accept = (state_q == IDLE) && start;
   assign mul_go = accept && (alucont == OP_MUL);

   seq_multiplier #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk      (clk),
      .reset    (reset),
      .go       (mul_go),
      .a        (a),
      .b        (b),
      .product  (product),
      .mul_done (mul_done)
   );

   // Control state register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: start is only honoured in IDLE, never queued.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = (alucont == OP_MUL) ? MULT : EXEC;
         EXEC:    state_d = IDLE;
         MULT:    if (mul_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (state_q == MULT);
   end

   assign done   = done_q;
   assign result = result_q;
   assign psr    = psr_q;

   // Arithmetic and shift datapath on the latched operands.
   always_comb begin
      cin  = (op_q == OP_ADDC) && psr_q[PSR_C];
      sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
      diff = {1'b0, a_q} - {1'b0, b_q};
      sh   = b_q[SHAMT_W-1:0];
      // Magnitude is one bit wider so the most negative amount does not wrap.
      if (sh[SHAMT_W-1]) mag = {1'b0, ~sh} + {{SHAMT_W{1'b0}}, 1'b1};
      else               mag = {1'b0, sh};
      // Shifts by WIDTH or more naturally yield zero.
      if (sh[SHAMT_W-1]) shift_res = a_q >> mag;
      else               shift_res = a_q << mag;
   end

   // Result/PSR next-state; flags not touched by an op hold their value.
   always_comb begin
      result_d = result_q;
      psr_d    = psr_q;
      done_d   = 1'b0;
      if (state_q == EXEC) begin
         done_d = 1'b1;
         case (op_q)
            OP_AND: result_d = a_q & b_q;
            OP_OR:  result_d = a_q | b_q;
            OP_XOR: result_d = a_q ^ b_q;
            OP_MOV: result_d = b_q;
            OP_LSH: result_d = shift_res;
            OP_ADD, OP_ADDC: begin
               result_d     = sum[WIDTH-1:0];
               psr_d[PSR_C] = sum[WIDTH];
               psr_d[PSR_F] = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum[WIDTH-1] != a_q[WIDTH-1]);
               psr_d[PSR_Z] = (sum[WIDTH-1:0] == '0);
               psr_d[PSR_N] = sum[WIDTH-1];
            end
            OP_SUB, OP_CMP: begin
               if (op_q == OP_SUB) result_d = diff[WIDTH-1:0];
               psr_d[PSR_C] = diff[WIDTH];
               psr_d[PSR_L] = diff[WIDTH];
               psr_d[PSR_F] = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff[WIDTH-1] != a_q[WIDTH-1]);
               psr_d[PSR_Z] = (diff[WIDTH-1:0] == '0);
               psr_d[PSR_N] = diff[WIDTH-1];
            end
            default: result_d = sum[WIDTH-1:0];
         endcase
      end else if ((state_q == MULT) && mul_done) begin
         done_d       = 1'b1;
         result_d     = product;
         psr_d[PSR_Z] = (product == '0);
         psr_d[PSR_N] = product[WIDTH-1];
      end
      psr_d[7:5] = 3'b000;
   end

   // Operand latch on accept, plus result/PSR/done registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         psr_q    <= '0;
         done_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= alucont;
         end
         result_q <= result_d;
         psr_q    <= psr_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for single-cycle ops, hand-written
// sequences for multiply, start-while-busy and mid-multiply reset.
module tb_alu_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [15:0] a, b;
   logic [3:0]  alucont;
   logic        busy, done;
   logic [15:0] result;
   logic [7:0]  psr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_seq #(
      .WIDTH      (16),
      .SHAMT_W    (5),
      .MUL_CYCLES (16)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .a       (a),
      .b       (b),
      .alucont (alucont),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .psr     (psr)
   );

   typedef struct packed {
      logic [3:0]  op;
      logic [15:0] va;
      logic [15:0] vb;
      logic [15:0] res;
      logic [7:0]  flags;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge with inputs scrambled.
   task automatic issue(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
      start   = 1'b1;
      alucont = op;
      a       = va;
      b       = vb;
      @(posedge clk); #1;
      start   = 1'b0;
      alucont = OP_ADD;
      a       = 16'hA5A5;
      b       = 16'h5A5A;
   endtask

   // Waits (bounded) for done; optionally pokes an ADD start at iteration poke_at.
   task automatic wait_done(input string name, input int exp_lat, input int exp_busy,
                            input int poke_at);
      int lat   = 0;
      int nbusy = 0;
      bit seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (i == poke_at) begin
            start = 1'b1; alucont = OP_ADD; a = 16'h0001; b = 16'h0001;
         end else if (i == poke_at + 1) begin
            start = 1'b0;
         end
         if (busy) nbusy++;
         @(posedge clk); #1;
         lat++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      check({name, " done seen"}, 32'(seen), 32'd1);
      check({name, " latency"}, lat, exp_lat);
      check({name, " busy cycles"}, nbusy, exp_busy);
      check({name, " busy low at done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int extra;

      vecs[0]  = '{OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 8'h06};
      vecs[1]  = '{OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 8'h18};
      vecs[2]  = '{OP_ADDC, 16'h0000, 16'h0000, 16'h0001, 8'h00};
      vecs[3]  = '{OP_MOV,  16'hDEAD, 16'h1234, 16'h1234, 8'h00};
      vecs[4]  = '{OP_CMP,  16'h0003, 16'h0005, 16'h1234, 8'h0B};
      vecs[5]  = '{OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 8'h0B};
      vecs[6]  = '{OP_OR,   16'hF0F0, 16'h0F00, 16'hFFF0, 8'h0B};
      vecs[7]  = '{OP_XOR,  16'hFFFF, 16'h0F0F, 16'hF0F0, 8'h0B};
      vecs[8]  = '{OP_LSH,  16'h00F0, 16'h001C, 16'h000F, 8'h0B};
      vecs[9]  = '{OP_LSH,  16'h00F0, 16'h0010, 16'h0000, 8'h0B};
      vecs[10] = '{OP_LSH,  16'h00F0, 16'h0004, 16'h0F00, 8'h0B};
      vecs[11] = '{OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 8'h04};
      vecs[12] = '{4'b1111, 16'h0003, 16'h0004, 16'h0007, 8'h04};
      vecs[13] = '{OP_ADD,  16'hFFFF, 16'hFFFF, 16'hFFFE, 8'h0A};
      vecs[14] = '{OP_ADDC, 16'h0001, 16'h0001, 16'h0003, 8'h00};
      vecs[15] = '{OP_LSH,  16'h0003, 16'h000F, 16'h8000, 8'h00};
      vecs[16] = '{OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 8'h0B};

      reset = 1'b1; start = 1'b0; a = '0; b = '0; alucont = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset result", result, 16'h0000);
      check("reset psr", psr, 8'h00);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      reset = 1'b0;

      // Single-cycle table, issued back to back (start every other cycle).
      for (int i = 0; i < 17; i++) begin
         issue(vecs[i].op, vecs[i].va, vecs[i].vb);
         wait_done($sformatf("vec%0d", i), 1, 0, -1);
         check($sformatf("vec%0d result", i), result, vecs[i].res);
         check($sformatf("vec%0d psr", i), psr, vecs[i].flags);
      end
      @(posedge clk); #1;
      check("done single pulse", 32'(done), 32'd0);

      // start held through EXEC: only the first request is taken.
      start = 1'b1; alucont = OP_ADD; a = 16'h0001; b = 16'h0002;
      @(posedge clk); #1;
      a = 16'h000A; b = 16'h0014;
      @(posedge clk); #1;
      check("hold done", 32'(done), 32'd1);
      check("hold result", result, 16'h0003);
      check("hold psr", psr, 8'h01);
      start = 1'b0;
      @(posedge clk); #1;
      check("hold no second done", 32'(done), 32'd0);
      check("hold result kept", result, 16'h0003);

      // MUL 300*200 with an ignored start while busy.
      issue(OP_MUL, 16'd300, 16'd200);
      wait_done("mul1", 16, 16, 3);
      check("mul1 result", result, 16'hEA60);
      check("mul1 psr", psr, 8'h03);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (done || busy) extra++;
      end
      check("mul1 no queued op", extra, 0);
      check("mul1 result kept", result, 16'hEA60);

      // MUL whose low bits are zero.
      issue(OP_MUL, 16'h0100, 16'h0100);
      wait_done("mul2", 16, 16, -1);
      check("mul2 result", result, 16'h0000);
      check("mul2 psr", psr, 8'h11);

      issue(OP_MOV, 16'h0000, 16'hBEEF);
      wait_done("mov", 1, 0, -1);
      check("mov result", result, 16'hBEEF);

      // Reset in the fifth busy cycle of a MUL.
      issue(OP_MUL, 16'd3, 16'd5);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("pre-reset busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort result", result, 16'h0000);
      check("abort psr", psr, 8'h00);
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (done || busy) extra++;
      end
      check("abort no late done", extra, 0);

      issue(OP_SUB, 16'd5, 16'd5);
      wait_done("sub after abort", 1, 0, -1);
      check("sub after abort result", result, 16'h0000);
      check("sub after abort psr", psr, 8'h10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
